// File: rtl/dr32e_fetch_fifo.sv
// Instruction fetch queue feeding the decoder: buffers fetched words with their PCs and
// redirects on flush. Optional per-entry bus-error storage under `DR32E_FETCH_ERR_EN.
module dr32e_fetch_fifo #(
  parameter int unsigned Depth    = 2,
  parameter logic [31:0] BootAddr = 32'h0000_0080
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [31:0] fetch_rdata_i,
  input  logic        fetch_err_i,
  output logic [31:0] fetch_addr_o,
  input  logic        clear_i,
  input  logic [31:0] clear_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_rdata_o,
  output logic [31:0] instr_rdata_alu_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_first_cycle_o,
  output logic        instr_fetch_err_o,
  input  logic        id_ready_i
);

  localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] r_rptr, r_wptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_fetch_addr;
  logic          r_first;

  logic [31:0]   r_rdata     [Depth];
  logic [31:0]   r_rdata_alu [Depth];
  logic [31:0]   r_pc        [Depth];

  logic [AW-1:0] w_rptr_nxt, w_wptr_nxt;
  logic [CW-1:0] w_count_nxt;
  logic [31:0]   w_fetch_addr_nxt;
  logic          w_first_nxt;
  logic          w_ready, w_valid, w_push, w_pop;

  assign w_ready = (r_count < CW'(Depth));
  assign w_valid = (r_count != '0);
  assign w_push  = fetch_valid_i & w_ready & ~clear_i;
  assign w_pop   = w_valid & id_ready_i & ~clear_i;

  always_comb begin
    w_rptr_nxt       = r_rptr;
    w_wptr_nxt       = r_wptr;
    w_count_nxt      = r_count;
    w_fetch_addr_nxt = r_fetch_addr;
    // Head is new next cycle if it was just consumed or the queue was empty.
    w_first_nxt      = w_pop | (r_count == '0);
    if (clear_i) begin
      w_rptr_nxt       = '0;
      w_wptr_nxt       = '0;
      w_count_nxt      = '0;
      w_fetch_addr_nxt = {clear_pc_i[31:2], 2'b00};
    end else begin
      if (w_push) begin
        w_wptr_nxt       = r_wptr + AW'(1);
        w_fetch_addr_nxt = r_fetch_addr + 32'd4;
      end
      if (w_pop) begin
        w_rptr_nxt = r_rptr + AW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + CW'(1);
        2'b01:   w_count_nxt = r_count - CW'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rptr       <= '0;
      r_wptr       <= '0;
      r_count      <= '0;
      r_fetch_addr <= BootAddr;
      r_first      <= 1'b1;
    end else begin
      r_rptr       <= w_rptr_nxt;
      r_wptr       <= w_wptr_nxt;
      r_count      <= w_count_nxt;
      r_fetch_addr <= w_fetch_addr_nxt;
      r_first      <= w_first_nxt;
    end
  end

  // Entry storage is reset so the head outputs read 0 out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(Depth); i++) begin
        r_rdata[i]     <= '0;
        r_rdata_alu[i] <= '0;
        r_pc[i]        <= '0;
      end
    end else if (w_push) begin
      r_rdata[r_wptr]     <= fetch_rdata_i;
      r_rdata_alu[r_wptr] <= fetch_rdata_i;
      r_pc[r_wptr]        <= r_fetch_addr;
    end
  end

`ifdef DR32E_FETCH_ERR_EN
  logic r_err [Depth];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(Depth); i++) begin
        r_err[i] <= 1'b0;
      end
    end else if (w_push) begin
      r_err[r_wptr] <= fetch_err_i;
    end
  end

  assign instr_fetch_err_o = r_err[r_rptr];
`else
  logic w_unused_fetch_err;
  assign w_unused_fetch_err = fetch_err_i;
  assign instr_fetch_err_o  = 1'b0;
`endif

  assign fetch_ready_o       = w_ready;
  assign fetch_addr_o        = r_fetch_addr;
  assign instr_valid_o       = w_valid;
  assign instr_rdata_o       = r_rdata[r_rptr];
  assign instr_rdata_alu_o   = r_rdata_alu[r_rptr];
  assign instr_pc_o          = r_pc[r_rptr];
  assign instr_first_cycle_o = r_first;

endmodule

// File: tb/tb_dr32e_fetch_fifo.sv
// Bench for dr32e_fetch_fifo: directed scenarios plus random traffic, checked against a
// queue-based reference model.
module tb_dr32e_fetch_fifo;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] BOOT  = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        fetch_valid_i;
  logic        fetch_ready_o;
  logic [31:0] fetch_rdata_i;
  logic        fetch_err_i;
  logic [31:0] fetch_addr_o;
  logic        clear_i;
  logic [31:0] clear_pc_i;
  logic        instr_valid_o;
  logic [31:0] instr_rdata_o;
  logic [31:0] instr_rdata_alu_o;
  logic [31:0] instr_pc_o;
  logic        instr_first_cycle_o;
  logic        instr_fetch_err_o;
  logic        id_ready_i;

  dr32e_fetch_fifo #(
    .Depth    (DEPTH),
    .BootAddr (BOOT)
  ) u_dut (
    .clk_i               (clk),
    .rst_i               (rst_i),
    .fetch_valid_i       (fetch_valid_i),
    .fetch_ready_o       (fetch_ready_o),
    .fetch_rdata_i       (fetch_rdata_i),
    .fetch_err_i         (fetch_err_i),
    .fetch_addr_o        (fetch_addr_o),
    .clear_i             (clear_i),
    .clear_pc_i          (clear_pc_i),
    .instr_valid_o       (instr_valid_o),
    .instr_rdata_o       (instr_rdata_o),
    .instr_rdata_alu_o   (instr_rdata_alu_o),
    .instr_pc_o          (instr_pc_o),
    .instr_first_cycle_o (instr_first_cycle_o),
    .instr_fetch_err_o   (instr_fetch_err_o),
    .id_ready_i          (id_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
    logic        err;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_addr;
  logic        m_first;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_addr  = BOOT;
    m_first = 1'b1;
  endfunction

  task automatic check_outputs(input string ctx);
    check_eq({ctx, "_ready"}, fetch_ready_o, m_q.size() < DEPTH);
    check_eq({ctx, "_valid"}, instr_valid_o, m_q.size() != 0);
    check_eq({ctx, "_addr"}, fetch_addr_o, m_addr);
    if (m_q.size() != 0) begin
      check_eq({ctx, "_rdata"}, instr_rdata_o, m_q[0].data);
      check_eq({ctx, "_alu"}, instr_rdata_alu_o, m_q[0].data);
      check_eq({ctx, "_pc"}, instr_pc_o, m_q[0].pc);
      check_eq({ctx, "_err"}, instr_fetch_err_o, m_q[0].err);
      check_eq({ctx, "_first"}, instr_first_cycle_o, m_first);
    end else begin
      check_eq({ctx, "_err_idle"}, instr_fetch_err_o, 1'b0);
    end
  endtask

  // Drives one cycle of inputs, advances the model, then checks after the edge.
  task automatic step(input string ctx, input logic fv, input logic [31:0] fd, input logic fe,
                      input logic clr, input logic [31:0] cpc, input logic idr);
    bit   can_push;
    bit   do_pop;
    ent_t e;
    fetch_valid_i = fv;
    fetch_rdata_i = fd;
    fetch_err_i   = fe;
    clear_i       = clr;
    clear_pc_i    = cpc;
    id_ready_i    = idr;
    can_push = (m_q.size() < DEPTH);
    if (clr) begin
      m_first = (m_q.size() == 0);
      m_q.delete();
      m_addr = cpc & 32'hFFFF_FFFC;
    end else begin
      do_pop  = (m_q.size() != 0) && idr;
      m_first = do_pop || (m_q.size() == 0);
      if (do_pop) void'(m_q.pop_front());
      if (fv && can_push) begin
        e.data = fd;
        e.pc   = m_addr;
`ifdef DR32E_FETCH_ERR_EN
        e.err  = fe;
`else
        e.err  = 1'b0;
`endif
        m_q.push_back(e);
        m_addr = m_addr + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    check_outputs(ctx);
  endtask

  initial begin
    rst_i         = 1'b1;
    fetch_valid_i = 1'b0;
    fetch_rdata_i = '0;
    fetch_err_i   = 1'b0;
    clear_i       = 1'b0;
    clear_pc_i    = '0;
    id_ready_i    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;

    check_eq("rst_ready", fetch_ready_o, 1'b1);
    check_eq("rst_addr", fetch_addr_o, 32'h80);
    check_eq("rst_valid", instr_valid_o, 1'b0);
    check_eq("rst_rdata", instr_rdata_o, 32'h0);
    check_eq("rst_alu", instr_rdata_alu_o, 32'h0);
    check_eq("rst_pc", instr_pc_o, 32'h0);
    check_eq("rst_first", instr_first_cycle_o, 1'b1);
    check_eq("rst_err", instr_fetch_err_o, 1'b0);

    // Back-to-back words with the decoder always ready.
    step("t1a", 1'b1, 32'h0000_0013, 1'b0, 1'b0, '0, 1'b1);
    check_eq("t1_w0", instr_rdata_o, 32'h0000_0013);
    check_eq("t1_pc0", instr_pc_o, 32'h80);
    check_eq("t1_first0", instr_first_cycle_o, 1'b1);
    step("t1b", 1'b1, 32'h0010_0093, 1'b0, 1'b0, '0, 1'b1);
    check_eq("t1_w1", instr_rdata_o, 32'h0010_0093);
    check_eq("t1_pc1", instr_pc_o, 32'h84);
    check_eq("t1_first1", instr_first_cycle_o, 1'b1);
    step("t1c", 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);

    // Fill with the decoder stalled; third word must be refused.
    step("t2a", 1'b1, 32'h0000_0013, 1'b0, 1'b0, '0, 1'b0);
    check_eq("t2_first_a", instr_first_cycle_o, 1'b1);
    step("t2b", 1'b1, 32'h0020_0113, 1'b0, 1'b0, '0, 1'b0);
    check_eq("t2_ready_low", fetch_ready_o, 1'b0);
    check_eq("t2_first_b", instr_first_cycle_o, 1'b0);
    step("t2c", 1'b1, 32'h0030_0193, 1'b0, 1'b0, '0, 1'b0);
    check_eq("t2_head", instr_rdata_o, 32'h0000_0013);

    // Flush while full, with a competing push.
    step("t3a", 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0000_1003, 1'b1);
    check_eq("t3_valid", instr_valid_o, 1'b0);
    check_eq("t3_addr", fetch_addr_o, 32'h0000_1000);
    step("t3b", 1'b1, 32'h0040_0213, 1'b0, 1'b0, '0, 1'b0);
    check_eq("t3_pc", instr_pc_o, 32'h0000_1000);

    // Occupancy held at one while streaming through pointer wraps.
    for (int i = 0; i < 8; i++) begin
      step("t4", 1'b1, 32'h0100_0000 + 32'(i), 1'b0, 1'b0, '0, 1'b1);
    end

    // Errored word followed by a clean word.
    step("t5a", 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    step("t5b", 1'b1, 32'hBAD0_0001, 1'b1, 1'b0, '0, 1'b0);
    step("t5c", 1'b1, 32'h600D_0002, 1'b0, 1'b0, '0, 1'b0);
    step("t5d", 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    step("t5e", 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    step("t5f", 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);

    // Asynchronous reset mid-cycle with two entries queued.
    step("t6a", 1'b1, 32'h0000_0aa1, 1'b0, 1'b0, '0, 1'b0);
    step("t6b", 1'b1, 32'h0000_0aa2, 1'b0, 1'b0, '0, 1'b0);
    fetch_valid_i = 1'b0;
    #2;
    rst_i = 1'b1;
    #1;
    check_eq("t6_valid_now", instr_valid_o, 1'b0);
    model_reset();
    @(posedge clk);
    #3;
    rst_i = 1'b0;
    @(posedge clk);
    #1;
    check_eq("t6_addr", fetch_addr_o, 32'h80);
    check_eq("t6_ready", fetch_ready_o, 1'b1);
    check_outputs("t6");

    for (int i = 0; i < 3000; i++) begin
      step("rnd", $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) == 1,
           $urandom_range(0, 31) == 0, $urandom, $urandom_range(0, 2) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dr32e_fetch_fifo.md
# dr32e_fetch_fifo

Instruction fetch buffer between instruction memory and the decoder: accepts 32-bit fetched words over a valid/ready handshake, queues up to `Depth` of them with their PCs, and presents the head entry to the ID stage as `instr_rdata_o`, `instr_rdata_alu_o` and `instr_first_cycle_o`. A flush, taken on jump, branch or exception, empties the queue and redirects the fetch address. It is the producer for the decoder's IF-ID inputs.

## Interface
Parameters:
- `Depth`, 2: number of queue entries; power of two, 2 to 8.
- `BootAddr`, 32'h0000_0080: fetch address after reset.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `fetch_valid_i`  in  1  fetched word present on `fetch_rdata_i`.
- `fetch_ready_o`  out  1  queue can accept a word this cycle.
- `fetch_rdata_i`  in  32  fetched instruction word.
- `fetch_err_i`  in  1  bus error for this word (used only with the macro enabled).
- `fetch_addr_o`  out  32  address of the next word the queue expects.
- `clear_i`  in  1  flush request.
- `clear_pc_i`  in  32  redirect address; bits [1:0] ignored, treated as 0.
- `instr_valid_o`  out  1  head entry valid.
- `instr_rdata_o`  out  32  head instruction.
- `instr_rdata_alu_o`  out  32  replica of `instr_rdata_o`, separate register copy for fan-out.
- `instr_pc_o`  out  32  PC of the head entry.
- `instr_first_cycle_o`  out  1  head is being presented for its first cycle.
- `instr_fetch_err_o`  out  1  head entry carries a bus error.
- `id_ready_i`  in  1  ID stage consumes the head this cycle.

## Operation
- Storage: `Depth` entries, each holding {rdata, rdata copy, pc, err}. Read and write pointers are log2(`Depth`) bits wide and wrap modulo `Depth`. Count is log2(`Depth`)+1 bits.
- Push: occurs when `fetch_valid_i & fetch_ready_o & ~clear_i`.
  - Writes the word at the write pointer, with pc = `fetch_addr_o`.
  - `fetch_addr_o` then increments by 4, wrapping modulo 2^32.
- Pop: occurs when `instr_valid_o & id_ready_i & ~clear_i`. Advances the read pointer.
- `fetch_ready_o` = (count < `Depth`). It is combinational from state only and never depends on `fetch_valid_i`.
- Simultaneous push and pop with count < `Depth`: count is unchanged and both pointers advance. When full, push is blocked even if a pop occurs in the same cycle.
- `instr_valid_o` = (count != 0). Head outputs are driven from the read-pointer entry.
- `instr_first_cycle_o`:
  - Is 1 when `instr_valid_o` is 1 and a pop occurred in the previous cycle.
  - Is also 1 when the queue was empty in the previous cycle.
  - Is otherwise 0, i.e. while the head is stalled.
  - It is registered; reset value is 1.
- Flush (`clear_i` = 1):
  - Count goes to 0 and both pointers go to 0.
  - `fetch_addr_o` is loaded with {`clear_pc_i`[31:2], 2'b00}.
  - Any same-cycle push or pop is discarded.
  - Flush has priority over every other event.
- Reset values:
  - `fetch_ready_o` = 1
  - `fetch_addr_o` = `BootAddr`
  - `instr_valid_o` = 0
  - `instr_rdata_o`, `instr_rdata_alu_o`, `instr_pc_o` = 0
  - `instr_first_cycle_o` = 1
  - `instr_fetch_err_o` = 0
- Assertion of reset mid-operation discards all entries immediately, because reset is asynchronous.

## Timing
- Latency from push to `instr_valid_o`: 1 cycle. There is no fall-through.
- Throughput: 1 word per cycle when `id_ready_i` is held high.
- After `clear_i`: `instr_valid_o` = 0 in the next cycle, and the first post-flush word is visible 1 cycle after it is pushed.
- `instr_rdata_o`, `instr_pc_o` and `instr_fetch_err_o` are stable while `instr_valid_o` is 1 and `id_ready_i` is 0.

## Configuration
- `DR32E_FETCH_ERR_EN` defined:
  - `fetch_err_i` is stored per entry and presented on `instr_fetch_err_o`.
  - An entry with err = 1 stays in the queue until popped or flushed, exactly like a normal entry.
- Not defined:
  - The err storage is not built.
  - `instr_fetch_err_o` is tied to 0 and `fetch_err_i` is ignored.

## Test plan
- Reset, then push words 0x00000013 and 0x00100093 on back-to-back cycles with `id_ready_i` = 1:
  - The words appear on consecutive cycles with pc 0x80 and 0x84.
  - `instr_first_cycle_o` = 1 on both.
- `Depth` = 2 with `id_ready_i` = 0, push 3 words:
  - `fetch_ready_o` drops after the 2nd push and the 3rd word is not accepted.
  - The head holds 0x00000013 with `instr_first_cycle_o` 1 then 0.
- Fill the queue, then assert `clear_i` with `clear_pc_i` = 0x00001003 together with `fetch_valid_i`:
  - Next cycle `instr_valid_o` = 0 and `fetch_addr_o` = 0x00001000.
  - The next pushed word gets pc 0x00001000.
- Hold count = 1 and push while popping for 8 cycles:
  - Count stays 1 and the pointers wrap correctly.
  - Each output word matches its input order.
- With `DR32E_FETCH_ERR_EN`, push a word with `fetch_err_i` = 1 followed by a clean word:
  - `instr_fetch_err_o` is 1 only while the first word is at the head.
  - Without the macro, it is 0 throughout.
- Assert `rst_i` asynchronously mid-cycle with 2 entries queued:
  - `instr_valid_o` goes to 0 immediately.
  - After release, `fetch_addr_o` = 0x80 and `fetch_ready_o` = 1.
